// File: rtl/case_5_prod_accum_if.sv
// case_5_prod_accum_if: ap control, product stream and sum stream of the accumulator.
interface case_5_prod_accum_if #(
    parameter int PROD_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int LEN_WIDTH  = 8
);
    logic                  ap_start;
    logic                  ap_idle;
    logic                  ap_ready;
    logic                  ap_done;
    logic [LEN_WIDTH-1:0]  len;
    logic [PROD_WIDTH-1:0] prod_tdata;
    logic                  prod_tvalid;
    logic                  prod_tready;
    logic [ACC_WIDTH-1:0]  sum_tdata;
    logic                  sum_tvalid;
    logic                  sum_tready;
    logic                  sat_flag;

    modport slave (
        input  ap_start, len, prod_tdata, prod_tvalid, sum_tready,
        output ap_idle, ap_ready, ap_done, prod_tready, sum_tdata, sum_tvalid, sat_flag
    );

    modport master (
        output ap_start, len, prod_tdata, prod_tvalid, sum_tready,
        input  ap_idle, ap_ready, ap_done, prod_tready, sum_tdata, sum_tvalid, sat_flag
    );
endinterface

// File: rtl/case_5_prod_accum.sv
// case_5_prod_accum: accumulates len signed products into a saturating sum, ap-style control.
module case_5_prod_accum #(
    parameter int PROD_WIDTH = 8,
    parameter int ACC_WIDTH  = 16,
    parameter int LEN_WIDTH  = 8
) (
    input logic ap_clk,
    input logic ap_rst_n,
    case_5_prod_accum_if.slave bus
);
    typedef enum logic [1:0] {IDLE, ACC, OUT} state_t;

    state_t                       state_q, state_d;
    logic signed [ACC_WIDTH-1:0]  acc_q, acc_d, sum_q, sum_d, sat_v;
    logic        [LEN_WIDTH-1:0]  count_q, count_d, len_q, len_d;
    logic                         sat_q, sat_d, ready_q, done_q;
    logic signed [ACC_WIDTH:0]    wide;
    logic                         start_ok, fire, last, ovf;

    assign start_ok = state_q == IDLE && bus.ap_start;
    assign fire     = state_q == ACC && bus.prod_tvalid;
    assign last     = fire && count_q + LEN_WIDTH'(1) == len_q;
    // One guard bit catches overflow; clamp direction follows the guard bit's sign.
    assign wide  = {acc_q[ACC_WIDTH-1], acc_q}
                 + {{(ACC_WIDTH+1-PROD_WIDTH){bus.prod_tdata[PROD_WIDTH-1]}}, bus.prod_tdata};
    assign ovf   = wide[ACC_WIDTH] != wide[ACC_WIDTH-1];
    assign sat_v = ovf ? {wide[ACC_WIDTH], {(ACC_WIDTH-1){~wide[ACC_WIDTH]}}} : wide[ACC_WIDTH-1:0];

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) state_q <= IDLE;
        else           state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.ap_start) state_d = bus.len == '0 ? OUT : ACC;
            ACC:     if (last) state_d = OUT;
            OUT:     if (bus.sum_tready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.ap_idle     = state_q == IDLE;
        bus.prod_tready = state_q == ACC;
        bus.sum_tvalid  = state_q == OUT;
        bus.ap_ready    = ready_q;
        bus.ap_done     = done_q;
        bus.sum_tdata   = sum_q;
        bus.sat_flag    = sat_q;
    end

    always_comb begin
        acc_d   = start_ok ? '0 : fire ? sat_v : acc_q;
        count_d = start_ok ? '0 : fire ? count_q + LEN_WIDTH'(1) : count_q;
        len_d   = start_ok ? bus.len : len_q;
        sat_d   = start_ok ? 1'b0 : sat_q | (fire & ovf);
        sum_d   = (start_ok && bus.len == '0) ? '0 : last ? sat_v : sum_q;
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            acc_q   <= '0;
            count_q <= '0;
            len_q   <= '0;
            sum_q   <= '0;
            sat_q   <= 1'b0;
            ready_q <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            count_q <= count_d;
            len_q   <= len_d;
            sum_q   <= sum_d;
            sat_q   <= sat_d;
            ready_q <= last;
            done_q  <= state_q == OUT && bus.sum_tready;
        end
    end
endmodule
